// File: rtl/mac_rx_parse.sv
// mac_rx_parse -- receive-side Ethernet/IPv4/UDP header parser.
// Consumes one byte per s_tvalid cycle inside the rx_en envelope. It checks
// the preamble/SFD, captures the Ethernet, IPv4 and UDP header fields into
// shadow registers, and publishes them (with a one-cycle hdr_valid pulse)
// once the UDP header is complete. UDP payload bytes go through a small FIFO
// to an AXI-Stream master port.
// Ports:
//   rx_clk, rst_n            clock, asynchronous active-low reset
//   rx_en                    frame envelope; a falling edge ends the frame
//   s_tvalid, s_tdata        byte strobe and byte from the nibble assembler
//   dst_mac .. UDP_CheckSum  header fields (big-endian), held until the next accepted header
//   hdr_valid                one-cycle pulse when the header fields update
//   m_axis_*                 payload stream; tuser marks a frame error on the tlast beat
//   drop_cnt                 saturating count of rejected frames
module mac_rx_parse #(
  parameter int FIFO_DEPTH = 32
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic        rx_en,
  input  logic        s_tvalid,
  input  logic [7:0]  s_tdata,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] eth_type,
  output logic [15:0] IP_TotLen,
  output logic [31:0] IP_SrcAddr,
  output logic [31:0] IP_DestAddr,
  output logic [15:0] UDP_SrcPort,
  output logic [15:0] UDP_DestPort,
  output logic [15:0] UDP_TotLen,
  output logic [15:0] UDP_CheckSum,
  output logic        hdr_valid,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_DATA = CW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, DROP} state_t;

  state_t        state;
  logic [4:0]    cnt;        // byte index inside the current header
  logic          armed;      // a new frame may start only after rx_en has been low
  logic          ovf;        // sticky: a payload byte of this frame was discarded
  logic [15:0]   pay_rem;    // payload bytes still expected
  logic [47:0]   sh_dst, sh_src;
  logic [15:0]   sh_type, sh_totlen, sh_sport, sh_dport, sh_ulen;
  logic [31:0]   sh_ipsrc, sh_ipdst;
  logic [7:0]    sh_csum_hi;

  logic [9:0]    mem [FIFO_DEPTH];   // {tuser, tlast, data}
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          push, pop, discard, reject;
  logic [9:0]    push_entry;
  logic [15:0]   ulen_now;

  assign ulen_now      = {sh_ulen[7:0], s_tdata};
  assign m_axis_tvalid = (count != {CW{1'b0}});
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr][7:0] : 8'h00;
  assign m_axis_tlast  = m_axis_tvalid & mem[rd_ptr][8];
  assign m_axis_tuser  = m_axis_tvalid & mem[rd_ptr][9];

  // FIFO write decision and header rejection checks for the current byte.
  // Data bytes keep one slot free so the closing tlast entry always fits.
  always_comb begin
    push       = 1'b0;
    push_entry = 10'd0;
    discard    = 1'b0;
    reject     = 1'b0;
    if (state == PAYLOAD) begin
      if (!rx_en) begin
        push_entry = {1'b1, 1'b1, 8'h00};
        push       = (count < DEPTH_FULL);
      end else if (s_tvalid) begin
        if (pay_rem == 16'd1) begin
          push_entry = {ovf, 1'b1, s_tdata};
          push       = (count < DEPTH_FULL);
        end else begin
          push_entry = {1'b0, 1'b0, s_tdata};
          push       = (count < DEPTH_DATA);
        end
      end else begin
        push = 1'b0;
      end
      discard = (!rx_en || s_tvalid) && !push;
    end else begin
      discard = 1'b0;
    end
    if (rx_en && s_tvalid) begin
      case (state)
        ETH_HDR: reject = (cnt == 5'd13) && ({sh_type[7:0], s_tdata} != 16'h0800);
        IP_HDR:  reject = ((cnt == 5'd0) && (s_tdata != 8'h45)) ||
                          ((cnt == 5'd9) && (s_tdata != 8'h11));
        UDP_HDR: reject = (cnt == 5'd5) && (ulen_now < 16'd8);
        default: reject = 1'b0;
      endcase
    end else begin
      reject = 1'b0;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates the outputs.
  always_ff @(posedge rx_clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Parser state machine, shadow capture, published header fields and drop counter.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;  cnt <= 5'd0;  armed <= 1'b0;  ovf <= 1'b0;  pay_rem <= 16'd0;
      sh_dst <= 48'd0;  sh_src <= 48'd0;  sh_type <= 16'd0;  sh_totlen <= 16'd0;
      sh_ipsrc <= 32'd0;  sh_ipdst <= 32'd0;  sh_sport <= 16'd0;  sh_dport <= 16'd0;
      sh_ulen <= 16'd0;  sh_csum_hi <= 8'd0;
      dst_mac <= 48'd0;  src_mac <= 48'd0;  eth_type <= 16'd0;  IP_TotLen <= 16'd0;
      IP_SrcAddr <= 32'd0;  IP_DestAddr <= 32'd0;  UDP_SrcPort <= 16'd0;
      UDP_DestPort <= 16'd0;  UDP_TotLen <= 16'd0;  UDP_CheckSum <= 16'd0;
      hdr_valid <= 1'b0;  drop_cnt <= 16'd0;
    end else begin
      hdr_valid <= 1'b0;
      if (!rx_en) begin
        // End of envelope: every state returns to IDLE and the next frame may start.
        state <= IDLE;
        armed <= 1'b1;
        ovf   <= 1'b0;
      end else if (s_tvalid) begin
        if (reject) begin
          state    <= DROP;
          drop_cnt <= (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
        end else begin
          case (state)
            IDLE: begin
              if (armed) begin
                armed <= 1'b0;
                state <= (s_tdata == 8'h55) ? PREAMBLE : DROP;
              end
            end
            PREAMBLE: begin
              cnt <= 5'd0;
              if (s_tdata == 8'hD5)      state <= ETH_HDR;
              else if (s_tdata != 8'h55) state <= DROP;
              else                       state <= PREAMBLE;
            end
            ETH_HDR: begin
              cnt <= cnt + 5'd1;
              if (cnt < 5'd6)       sh_dst  <= {sh_dst[39:0], s_tdata};
              else if (cnt < 5'd12) sh_src  <= {sh_src[39:0], s_tdata};
              else                  sh_type <= {sh_type[7:0], s_tdata};
              if (cnt == 5'd13) begin
                state <= IP_HDR;
                cnt   <= 5'd0;
              end
            end
            IP_HDR: begin
              cnt <= cnt + 5'd1;
              if (cnt == 5'd2 || cnt == 5'd3)        sh_totlen <= {sh_totlen[7:0], s_tdata};
              else if (cnt >= 5'd12 && cnt < 5'd16)  sh_ipsrc  <= {sh_ipsrc[23:0], s_tdata};
              else if (cnt >= 5'd16)                 sh_ipdst  <= {sh_ipdst[23:0], s_tdata};
              if (cnt == 5'd19) begin
                state <= UDP_HDR;
                cnt   <= 5'd0;
              end
            end
            UDP_HDR: begin
              cnt <= cnt + 5'd1;
              case (cnt)
                5'd0, 5'd1: sh_sport <= {sh_sport[7:0], s_tdata};
                5'd2, 5'd3: sh_dport <= {sh_dport[7:0], s_tdata};
                5'd4:       sh_ulen  <= {sh_ulen[7:0], s_tdata};
                5'd5: begin
                  sh_ulen <= ulen_now;
                  pay_rem <= ulen_now - 16'd8;
                end
                5'd6:       sh_csum_hi <= s_tdata;
                default: begin
                  // Last header byte: publish everything at once.
                  dst_mac <= sh_dst;  src_mac <= sh_src;  eth_type <= sh_type;
                  IP_TotLen <= sh_totlen;  IP_SrcAddr <= sh_ipsrc;  IP_DestAddr <= sh_ipdst;
                  UDP_SrcPort <= sh_sport;  UDP_DestPort <= sh_dport;  UDP_TotLen <= sh_ulen;
                  UDP_CheckSum <= {sh_csum_hi, s_tdata};
                  hdr_valid <= 1'b1;
                  ovf       <= 1'b0;
                  cnt       <= 5'd0;
                  // A zero-length payload returns to IDLE disarmed, so trailing bytes are ignored.
                  state     <= (pay_rem == 16'd0) ? IDLE : PAYLOAD;
                end
              endcase
            end
            PAYLOAD: begin
              pay_rem <= pay_rem - 16'd1;
              if (pay_rem == 16'd1) begin
                state <= DROP;
                ovf   <= 1'b0;
              end else if (discard) begin
                ovf <= 1'b1;
              end
            end
            DROP:    state <= DROP;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/mac_rx_parse.md
MAC_RX_PARSE -- requirements
Module: mac_rx_parse

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 32, payload FIFO entries (power of 2, ≥8).
REQ-002 SHALL have ports, clock and reset first:
- rx_clk  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- rx_en  in  1  frame envelope; a falling edge ends the frame
- s_tvalid  in  1  byte strobe from nibble assembler
- s_tdata  in  8  received byte
- dst_mac, src_mac  out  48  Ethernet addresses
- eth_type  out  16
- IP_TotLen, IP_SrcAddr, IP_DestAddr  out  16/32/32
- UDP_SrcPort, UDP_DestPort, UDP_TotLen, UDP_CheckSum  out  16 each
- hdr_valid  out  1  one-cycle pulse when the header fields update
- m_axis_tdata  out  8  payload byte
- m_axis_tvalid, m_axis_tlast, m_axis_tuser  out  1  AXI-Stream; tuser = frame error, valid on tlast beat
- m_axis_tready  in  1
- drop_cnt  out  16  count of rejected frames, saturating

Function
REQ-003 SHALL use states IDLE, PREAMBLE, ETH_HDR (14 B), IP_HDR (20 B), UDP_HDR (8 B), PAYLOAD, DROP; one byte is consumed per s_tvalid cycle.
REQ-004 IDLE->PREAMBLE when rx_en=1 and s_tvalid with byte 0x55; a first byte other than 0x55 -> DROP.
REQ-005 PREAMBLE: 0x55 stays; 0xD5 -> ETH_HDR; any other byte -> DROP.
REQ-006 All header fields SHALL be big-endian, first byte = MSB, captured into shadow registers.
REQ-007 Reject to DROP: eth_type≠0x0800; IP byte0≠0x45; IP protocol (byte 9)≠0x11; UDP_TotLen<8. Each rejection increments drop_cnt exactly once.
REQ-008 On the 8th UDP header byte: copy shadows to outputs and pulse hdr_valid the next cycle; outputs hold until the next accepted header.
REQ-009 Payload length = UDP_TotLen−8. If 0 -> IDLE with no stream output; otherwise -> PAYLOAD.
REQ-010 PAYLOAD: write each byte to the FIFO as {tuser,tlast,data}; tlast=1 on byte number UDP_TotLen−8; then -> DROP to discard padding/FCS.
REQ-011 Any state: rx_en falling -> IDLE. In PAYLOAD before the final byte, write a terminator entry {tuser=1, tlast=1, data=0x00} and do not count it as a drop.
REQ-012 DROP SHALL ignore bytes until rx_en=0, then -> IDLE.
REQ-013 FIFO: non-final payload bytes are written only when occupancy < FIFO_DEPTH−1; final/terminator entries when occupancy < FIFO_DEPTH. Any discarded byte sets a sticky overflow flag, which forces tuser=1 on that frame's tlast entry.
REQ-014 Output: m_axis_tvalid = FIFO non-empty; an entry pops when tvalid&&tready; tdata/tlast/tuser are stable while tvalid&&!tready; simultaneous push and pop keep occupancy unchanged.
REQ-015 Latency: a written byte appears on m_axis_tvalid 1 cycle later (registered FIFO read) when the FIFO was empty and tready=1.
REQ-016 drop_cnt SHALL saturate at 0xFFFF.

Reset
REQ-017 While rst_n=0: state IDLE, FIFO empty, all header outputs 0, hdr_valid 0, m_axis_tvalid/tlast/tuser 0, drop_cnt 0, overflow flag 0.
REQ-018 Reset assertion mid-frame SHALL discard the FIFO contents; after release, bytes are ignored until rx_en has been low at least one cycle.

Verification
REQ-019 Valid frame: 7×0x55, 0xD5, dst 01:02:03:04:05:06, type 0x0800, IP 0x45 proto 0x11, src 192.168.1.10, UDP ports 1234→5678, UDP_TotLen 12, payload AA BB CC DD, tready=1 -> hdr_valid one pulse, UDP_TotLen=0x000C, 4 beats with tlast on 0xDD, tuser=0.
REQ-020 eth_type 0x0806 -> no stream output, no hdr_valid, drop_cnt increments by 1.
REQ-021 UDP_TotLen 20, rx_en drops after 5 payload bytes -> 5 beats, then 0x00 beat with tlast=1, tuser=1.
REQ-022 tready=0 throughout a 40-byte payload with FIFO_DEPTH 32 -> 31 bytes stored plus a final entry; draining shows tlast with tuser=1.
REQ-023 Random tready toggling on a 100-byte payload -> all bytes in order, no loss, tdata stable while stalled.
REQ-024 rst_n pulsed low mid-payload -> outputs at their reset values; the following valid frame is parsed correctly.
